instruction_loader: RTL and testbench
=====================================

# instruction_loader

Byte-serial program loader that fills the instruction memory before the processor runs. It accepts a valid/ready byte stream containing a word-count header followed by big-endian 32-bit instruction words. It issues one write per word into the instruction memory's write port at word-aligned byte addresses, and it holds the CPU stalled until loading completes. It sits between the host/debug link and the instruction-fetch stage, on the write side of the instruction memory.

## Interface
Parameters:
- BASE_ADDRESS, 32'd4: byte address of the first written word. Must be word-aligned. Address 0 is left for the reserved null instruction.
- DEPTH, 256: instruction memory capacity in words. The header count limit is DEPTH - BASE_ADDRESS/4.

Ports:
- clock  in  1  single system clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- byte_data  in  8  incoming stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- write_enable  out  1  one-cycle write strobe to instruction memory.
- write_address  out  32  byte address of the word being written; bits [1:0] always 0.
- write_data  out  32  instruction word; first stream byte lands in bits [31:24].
- load_done  out  1  high once loading has finished; stays high until reset.
- length_error  out  1  header count exceeded capacity; sticky until reset.
- checksum_error  out  1  checksum mismatch, sticky. Only driven when LOADER_CHECKSUM_EN is set, otherwise tied 0.
- cpu_stall  out  1  holds the processor; high from reset until load_done.

## Operation
- A byte transfers only on a cycle where byte_valid && byte_ready.
- States:
  - COUNT_HI: the accepted byte becomes count[15:8]; go to COUNT_LO.
  - COUNT_LO: the accepted byte becomes count[7:0]. Then:
    - count == 0: go to DONE.
    - count > limit: set length_error and go to DONE; no writes are issued.
    - otherwise go to DATA.
  - DATA: shift each accepted byte into the word assembly register, MSB first. After the 4th byte, go to WRITE.
  - WRITE: byte_ready = 0. Drive write_enable = 1 with the current write_address and the assembled write_data. Then:
    - write_address += 4.
    - words_remaining -= 1.
    - If words_remaining reaches 0, go to CHECK (macro set) or DONE. Otherwise go to DATA.
  - CHECK: accept one byte and compare it with the running XOR of all data bytes. On mismatch set checksum_error. Go to DONE.
  - DONE: byte_ready = 0, load_done = 1, cpu_stall = 0. Bytes offered here are ignored and stay unconsumed.
- byte_ready is 1 in COUNT_HI, COUNT_LO, DATA and CHECK, and 0 in WRITE and DONE.
- The byte counter within a word wraps 3→0. write_address never exceeds BASE_ADDRESS + 4*(limit-1).
- Header bytes are excluded from the checksum.

## Timing
- Reset values: state = COUNT_HI, byte_ready = 1, write_enable = 0, write_address = BASE_ADDRESS, write_data = 0, load_done = 0, length_error = 0, checksum_error = 0, cpu_stall = 1. Internal count and XOR registers are 0.
- Reset asserted mid-load aborts on the next edge and all outputs return to reset values. Words already written stay in memory.
- write_enable asserts the cycle after the 4th byte of a word is accepted and lasts exactly 1 cycle.
- Sustained rate with byte_valid held high: 5 cycles per word (4 bytes plus 1 WRITE cycle).
- load_done rises the cycle after the final WRITE (or the CHECK byte). cpu_stall falls in that same cycle.
- write_address and write_data are stable only while write_enable = 1.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last word, the CHECK state consumes one trailing XOR byte.
  - checksum_error is live.
  - load_done still asserts on mismatch; the CPU is released with the error flagged.
- LOADER_CHECKSUM_EN undefined:
  - There is no CHECK state, no XOR register, and no trailing byte.
  - checksum_error is constant 0.
  - DONE follows the last WRITE directly.

## Test plan
- Count 0x0002, then words 0x0C000412 and 0x0C000722 with valid held high → write pulses to 0x4 and 0x8 with those data, 5 cycles apart. load_done is high 1 cycle after the second write and cpu_stall = 0.
- Same stream with byte_valid toggled every other cycle → identical writes and data. No byte is lost or duplicated. byte_ready = 0 in every WRITE cycle.
- Count 0x0000 → no write_enable. load_done is high the cycle after the second header byte.
- Count 0x0100 with DEPTH = 256 and BASE_ADDRESS = 4 (limit 255) → length_error = 1, load_done = 1, zero writes.
- Reset pulled low after 6 bytes of a 2-word load → outputs return to reset values. A fresh 1-word stream then writes to 0x4.
- With LOADER_CHECKSUM_EN: 1 word 0x11223344 followed by checksum 0x44 → checksum_error = 0. The same word followed by 0x45 → checksum_error = 1 and load_done = 1.

Source files
------------

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-serial loader filling instruction memory, CPU held in stall until done
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'd4,
  parameter int unsigned DEPTH        = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        write_enable,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic        load_done,
  output logic        length_error,
  output logic        checksum_error,
  output logic        cpu_stall
);

  localparam logic [31:0] LIMIT = 32'(DEPTH) - (BASE_ADDRESS >> 2);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_COUNT_HI = 3'd0,
    S_COUNT_LO = 3'd1,
    S_DATA     = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4,
    S_CHECK    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_COUNT_HI = 3'd0,
    S_COUNT_LO = 3'd1,
    S_DATA     = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;
`endif

  state_t      state_q;
  logic        byte_ready_q;
  logic        write_enable_q;
  logic [31:0] write_address_q;
  logic [31:0] write_data_q;
  logic        load_done_q;
  logic        length_error_q;
  logic        cpu_stall_q;
  logic [7:0]  count_hi_q;
  logic [15:0] words_left_q;
  logic [23:0] word_q;
  logic [1:0]  byte_cnt_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
  logic        checksum_error_q;
`endif

  logic        accept;
  logic [15:0] count_d;
  logic [31:0] write_data_d;
  logic        last_word;

  assign accept       = byte_valid && byte_ready_q;
  assign count_d      = {count_hi_q, byte_data};
  assign write_data_d = {word_q, byte_data};
  assign last_word    = (words_left_q == 16'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= S_COUNT_HI;
      byte_ready_q     <= 1'b1;
      write_enable_q   <= 1'b0;
      write_address_q  <= BASE_ADDRESS;
      write_data_q     <= 32'd0;
      load_done_q      <= 1'b0;
      length_error_q   <= 1'b0;
      cpu_stall_q      <= 1'b1;
      count_hi_q       <= 8'd0;
      words_left_q     <= 16'd0;
      word_q           <= 24'd0;
      byte_cnt_q       <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_q            <= 8'd0;
      checksum_error_q <= 1'b0;
`endif
    end else begin
      write_enable_q <= 1'b0;
      case (state_q)
        S_COUNT_HI: begin
          if (accept) begin
            count_hi_q <= byte_data;
            state_q    <= S_COUNT_LO;
          end
        end
        S_COUNT_LO: begin
          if (accept) begin
            words_left_q <= count_d;
            if (count_d == 16'd0 || {16'd0, count_d} > LIMIT) begin
              length_error_q <= (count_d != 16'd0);
              state_q        <= S_DONE;
              byte_ready_q   <= 1'b0;
              load_done_q    <= 1'b1;
              cpu_stall_q    <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word_q     <= write_data_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_q ^ byte_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              state_q        <= S_WRITE;
              byte_ready_q   <= 1'b0;
              write_enable_q <= 1'b1;
              write_data_q   <= write_data_d;
            end
          end
        end
        S_WRITE: begin
          words_left_q <= words_left_q - 16'd1;
          // Address holds on the final word so it never steps past the last slot.
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_q      <= S_CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= S_DONE;
            load_done_q  <= 1'b1;
            cpu_stall_q  <= 1'b0;
`endif
          end else begin
            write_address_q <= write_address_q + 32'd4;
            state_q         <= S_DATA;
            byte_ready_q    <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            if (byte_data != xor_q) checksum_error_q <= 1'b1;
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            load_done_q  <= 1'b1;
            cpu_stall_q  <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          byte_ready_q <= 1'b0;
        end
        default: begin
          state_q      <= S_DONE;
          byte_ready_q <= 1'b0;
          load_done_q  <= 1'b1;
          cpu_stall_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready    = byte_ready_q;
  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign load_done     = load_done_q;
  assign length_error  = length_error_q;
  assign cpu_stall     = cpu_stall_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_error = checksum_error_q;
`else
  assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - table-driven scoreboard bench for instruction_loader
module tb_instruction_loader;

  localparam logic [31:0] BASE = 32'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        write_enable;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic        load_done;
  logic        length_error;
  logic        checksum_error;
  logic        cpu_stall;

  instruction_loader dut (
    .clock          (clock),
    .reset          (reset),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .load_done      (load_done),
    .length_error   (length_error),
    .checksum_error (checksum_error),
    .cpu_stall      (cpu_stall)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    logic        rdy;
  } wr_t;

  wr_t obs[$];
  wr_t exp_q[$];
  wr_t mon_w;

  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      mon_w.addr = write_address;
      mon_w.data = write_data;
      mon_w.cyc  = cyc;
      mon_w.rdy  = byte_ready;
      obs.push_back(mon_w);
    end
  end

  int errors = 0;
  int checks = 0;
  int last_acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (byte_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end
    end
    byte_valid   = 1'b0;
    last_acc_cyc = cyc;
    if (!ok) chk("byte_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset();
    chk("rst byte_ready", {31'd0, byte_ready}, 32'd1);
    chk("rst write_enable", {31'd0, write_enable}, 32'd0);
    chk("rst write_address", write_address, BASE);
    chk("rst write_data", write_data, 32'd0);
    chk("rst load_done", {31'd0, load_done}, 32'd0);
    chk("rst length_error", {31'd0, length_error}, 32'd0);
    chk("rst checksum_error", {31'd0, checksum_error}, 32'd0);
    chk("rst cpu_stall", {31'd0, cpu_stall}, 32'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] word_of(input int i, input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return {b, ~b, 8'hA5, b};
  endfunction

  task automatic run_stream(input string tag, input logic [15:0] count,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input bit toggle, input bit exp_len, input bit do_rst,
                            input logic [7:0] csum_adj, input bit exp_csum);
    int          nw;
    int          exp_done;
    int          done_cyc;
    int          nobs;
    bit          seen;
    logic [7:0]  x;
    logic [31:0] w;
    wr_t         e;
    if (do_rst) do_reset();
    obs.delete();
    exp_q.delete();
    nw = exp_len ? 0 : int'(count);
    x  = 8'd0;
    send_byte(count[15:8], 1'b0);
    send_byte(count[7:0], toggle);
    for (int i = 0; i < nw; i++) begin
      w      = word_of(i, w0, w1);
      e.addr = BASE + 32'(4 * i);
      e.data = w;
      e.cyc  = 0;
      e.rdy  = 1'b0;
      exp_q.push_back(e);
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[8*k +: 8], toggle);
        x = x ^ w[8*k +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (nw > 0) send_byte(x ^ csum_adj, toggle);
`endif
    seen     = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (load_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    chk({tag, " load_done"}, {31'd0, seen}, 32'd1);
    nobs = obs.size();
    chk({tag, " write_count"}, 32'(nobs), 32'(exp_q.size()));
    for (int i = 0; i < nobs && i < exp_q.size(); i++) begin
      chk({tag, " addr"}, obs[i].addr, exp_q[i].addr);
      chk({tag, " data"}, obs[i].data, exp_q[i].data);
      chk({tag, " ready_in_write"}, {31'd0, obs[i].rdy}, 32'd0);
      if (!toggle && i > 0) chk({tag, " write_gap"}, 32'(obs[i].cyc - obs[i-1].cyc), 32'd5);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_done = last_acc_cyc;
`else
    exp_done = (nw > 0 && nobs >= nw) ? obs[nw-1].cyc + 1 : last_acc_cyc;
`endif
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, " cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, " length_error"}, {31'd0, length_error}, {31'd0, exp_len});
`ifdef LOADER_CHECKSUM_EN
    chk({tag, " checksum_error"}, {31'd0, checksum_error}, {31'd0, exp_csum});
`else
    chk({tag, " checksum_error"}, {31'd0, checksum_error}, 32'd0);
    if (exp_csum) chk({tag, " csum_expectation"}, 32'd0, 32'd1);
`endif
    // A byte offered after completion must stay unconsumed.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) @(negedge clock);
    chk({tag, " done_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, " done_no_write"}, 32'(obs.size()), 32'(nobs));
    byte_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [15:0] count;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          toggle;
    bit          exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"two_words",   16'h0002, 32'h0C000412, 32'h0C000722, 1'b0, 1'b0};
    vecs[1] = '{"two_toggle",  16'h0002, 32'h0C000412, 32'h0C000722, 1'b1, 1'b0};
    vecs[2] = '{"zero_count",  16'h0000, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[3] = '{"over_limit",  16'h0100, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[4] = '{"one_ones",    16'h0001, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
    vecs[5] = '{"at_limit",    16'h00FF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 1'b0};
    vecs[6] = '{"max_count",   16'hFFFF, 32'h0,        32'h0,        1'b0, 1'b1};

    for (int v = 0; v < 7; v++)
      run_stream(vecs[v].tag, vecs[v].count, vecs[v].w0, vecs[v].w1,
                 vecs[v].toggle, vecs[v].exp_len, 1'b1, 8'h00, 1'b0);

    // Abort a two-word load after six bytes; the first word has already been written.
    do_reset();
    obs.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h12, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_reset();
    chk("abort write_count", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      chk("abort addr", obs[0].addr, 32'h4);
      chk("abort data", obs[0].data, 32'h0C000412);
    end
    reset = 1'b1;
    run_stream("after_abort", 16'h0001, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    run_stream("csum_good", 16'h0001, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    run_stream("csum_bad",  16'h0001, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
